// File: rtl/miriscv_arb_pkg.sv
// miriscv_arb_pkg: master indices and default lock bound for the data-port arbiter.
package miriscv_arb_pkg;
   localparam int ARB_M_CORE   = 0;
   localparam int ARB_M_EXT    = 1;
   localparam int ARB_MAX_LOCK = 8;
endpackage

// File: rtl/miriscv_arb_prio.sv
// miriscv_arb_prio: round-robin priority register with a bounded lock counter for master 1.
module miriscv_arb_prio
   import miriscv_arb_pkg::*;
#(
   parameter int MAX_LOCK = ARB_MAX_LOCK
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       core_req_i,
   input  logic       lock_i,
   input  logic [1:0] gnt_i,
   output logic       prio_o
);
   localparam int CW = $clog2(MAX_LOCK + 1);
   logic          prio_q, prio_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;
   // A saturated lock counter overrides the register so the core gets the next contended slot.
   assign prio_o = (lock_cnt_q == CW'(MAX_LOCK)) ? 1'(ARB_M_CORE) : prio_q;
   always_comb begin
      prio_d     = gnt_i[ARB_M_CORE] ? 1'(ARB_M_EXT) : gnt_i[ARB_M_EXT] ? lock_i : prio_q;
      lock_cnt_d = (!lock_i || gnt_i[ARB_M_CORE]) ? '0
                 : gnt_i[ARB_M_EXT] ? lock_cnt_q + CW'(core_req_i) : lock_cnt_q;
   end
   always_ff @(posedge clk_i or posedge rst_n_i) begin
      if (rst_n_i) begin
         prio_q     <= 1'b0;
         lock_cnt_q <= '0;
      end else begin
         prio_q     <= prio_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end
endmodule

// File: rtl/miriscv_data_arb.sv
// miriscv_data_arb: shares the data-memory port between the LSU (master 0) and an external master (master 1).
module miriscv_data_arb
   import miriscv_arb_pkg::*;
#(
   parameter int MAX_LOCK = ARB_MAX_LOCK
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [1:0]  req_i,
   input  logic [1:0]  we_i,
   input  logic [7:0]  be_i,
   input  logic [63:0] addr_i,
   input  logic [63:0] wdata_i,
   input  logic        lock_i,
   output logic [1:0]  gnt_o,
   output logic [1:0]  rvalid_o,
   output logic [31:0] rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);
   logic       prio;
   logic       sel;
   logic [1:0] rvalid_q, rvalid_d;
   miriscv_arb_prio #(.MAX_LOCK(MAX_LOCK)) u_prio (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .core_req_i (req_i[ARB_M_CORE]),
      .lock_i     (lock_i),
      .gnt_i      (gnt_o),
      .prio_o     (prio)
   );
   always_comb begin
      gnt_o[ARB_M_CORE] = req_i[ARB_M_CORE] & (~req_i[ARB_M_EXT] | ~prio);
      gnt_o[ARB_M_EXT]  = req_i[ARB_M_EXT] & (~req_i[ARB_M_CORE] | prio);
      sel               = gnt_o[ARB_M_EXT];
      mem_req_o         = |req_i;
      mem_we_o          = mem_req_o & (sel ? we_i[1] : we_i[0]);
      mem_be_o          = !mem_req_o ? '0 : sel ? be_i[7:4] : be_i[3:0];
      mem_addr_o        = !mem_req_o ? '0 : sel ? addr_i[63:32] : addr_i[31:0];
      mem_wdata_o       = !mem_req_o ? '0 : sel ? wdata_i[63:32] : wdata_i[31:0];
      rvalid_d          = gnt_o & ~we_i;
   end
   always_ff @(posedge clk_i or posedge rst_n_i) begin
      if (rst_n_i) rvalid_q <= '0;
      else         rvalid_q <= rvalid_d;
   end
   assign rvalid_o = rvalid_q;
   assign rdata_o  = mem_rdata_i;
endmodule

// File: tb/tb_miriscv_data_arb.sv
// tb_miriscv_data_arb: vector table for grants and mem muxing, scoreboard queue for read returns.
module tb_miriscv_data_arb;
   typedef struct {
      logic [1:0]  req;
      logic [1:0]  we;
      logic        lock;
      logic [1:0]  eg;
      logic [31:0] rd;
   } vec_t;
   typedef struct {
      logic [1:0]  rv;
      logic [31:0] d;
   } sb_t;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b1;
   logic [1:0]  req_i = '0, we_i = '0;
   logic [7:0]  be_i = '0;
   logic [63:0] addr_i = '0, wdata_i = '0;
   logic        lock_i = 1'b0;
   logic [1:0]  gnt_o, rvalid_o;
   logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   int          checks = 0, failures = 0;
   vec_t        tbl[$];
   sb_t         sb[$];

   miriscv_data_arb #(.MAX_LOCK(3)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .lock_i(lock_i), .gnt_o(gnt_o),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // Called just after a rising edge; returns just after the next one.
   task automatic step(input vec_t v, input int i, input string nm);
      sb_t         e;
      logic [69:0] em;
      int          m;
      req_i   = v.req;
      we_i    = v.we;
      lock_i  = v.lock;
      be_i    = 8'h3F;
      addr_i  = {32'h1000_0020 + 32'(i * 4), 32'h10 + 32'(i * 4)};
      wdata_i = {32'h1234 | 32'(i << 16), 32'hC0DE_0000 | 32'(i)};
      e = '{2'b00, 32'h0};
      if (sb.size() > 0) e = sb.pop_front();
      mem_rdata_i = (e.rv != 0) ? e.d : $urandom;
      @(negedge clk_i);
      chk($sformatf("%s rvalid", nm), 128'(rvalid_o), 128'(e.rv));
      if (e.rv != 0) chk($sformatf("%s rdata", nm), 128'(rdata_o), 128'(e.d));
      chk($sformatf("%s gnt", nm), 128'(gnt_o), 128'(v.eg));
      m  = v.eg[1] ? 1 : 0;
      em = (v.eg == 0) ? '0 : {1'b1, we_i[m], be_i[m*4 +: 4], addr_i[m*32 +: 32], wdata_i[m*32 +: 32]};
      chk($sformatf("%s mem", nm), 128'({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 128'(em));
      sb.push_back('{v.eg & ~v.we, v.rd});
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // MAX_LOCK = 3; comments give prio/lock_cnt after each row.
      tbl.push_back('{2'b01, 2'b00, 1'b0, 2'b01, 32'hDEADBEEF}); // p1
      tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 32'h0});
      tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b10, 32'h1111_0001}); // p0
      tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b01, 32'h1111_0002}); // p1
      tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b10, 32'h1111_0003}); // p0
      tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b01, 32'h1111_0004}); // p1
      tbl.push_back('{2'b10, 2'b10, 1'b0, 2'b10, 32'h0});         // m1 write, p0
      tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 32'h0});
      tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b01, 32'h2222_0001}); // lock ignored, p1
      tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b10, 32'h2222_0002}); // c1
      tbl.push_back('{2'b11, 2'b01, 1'b1, 2'b10, 32'h2222_0003}); // c2
      tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b10, 32'h2222_0004}); // c3
      tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b01, 32'h2222_0005}); // forced, c0 p1
      tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b10, 32'h2222_0006}); // c1
      tbl.push_back('{2'b10, 2'b00, 1'b1, 2'b10, 32'h2222_0007}); // uncontended, c1
      tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b10, 32'h2222_0008}); // c2
      tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b10, 32'h2222_0009}); // c3
      tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b01, 32'h2222_000A}); // forced, c0 p1
      tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b10, 32'h3333_0001}); // c1
      tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b10, 32'h3333_0002}); // c2
      tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 32'h0});         // lock drop clears, c0
      tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b10, 32'h3333_0003}); // c1
      tbl.push_back('{2'b11, 2'b10, 1'b1, 2'b10, 32'h3333_0004}); // c2
      tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b10, 32'h3333_0005}); // c3
      tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b01, 32'h3333_0006}); // saturated forces core, p1
      tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b10, 32'h3333_0007}); // drop+grant m1 -> p0
      tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b01, 32'h3333_0008}); // p1
      tbl.push_back('{2'b01, 2'b01, 1'b0, 2'b01, 32'h0});         // m0 write, p1
      tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 32'h0});

      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("reset gnt", 128'(gnt_o), 128'(2'b00));
      chk("reset rvalid", 128'(rvalid_o), 128'(2'b00));
      chk("reset mem", 128'({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 128'(0));
      @(posedge clk_i);
      #1 rst_n_i = 1'b0;
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i, $sformatf("v%0d", i));

      // Reset during the read-return cycle must drop the pending rvalid and clear priority.
      step('{2'b01, 2'b00, 1'b0, 2'b01, 32'h5555_AAAA}, 40, "rst_rd");
      req_i = '0;
      chk("rst_pre rvalid", 128'(rvalid_o), 128'(2'b01));
      #1 rst_n_i = 1'b1;
      #1 chk("rst_mid rvalid", 128'(rvalid_o), 128'(2'b00));
      sb.delete();
      repeat (2) @(posedge clk_i);
      #1 rst_n_i = 1'b0;
      step('{2'b00, 2'b00, 1'b0, 2'b00, 32'h0}, 41, "rst_idle");
      step('{2'b11, 2'b00, 1'b0, 2'b01, 32'h6666_0001}, 42, "rst_cont");
      step('{2'b11, 2'b00, 1'b0, 2'b10, 32'h6666_0002}, 43, "rst_rr");
      step('{2'b00, 2'b00, 1'b0, 2'b00, 32'h0}, 44, "tail0");
      step('{2'b00, 2'b00, 1'b0, 2'b00, 32'h0}, 45, "tail1");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
